// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: walks round keys 10 down to 0 with a valid/ready handshake.
// Optional INV_KEY_EXP_FWD_DERIVE_EN: accept the cipher key and derive the round-10 key first.
module inv_key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ROUND_W = 4;

  localparam logic [STATE_W-1:0] IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] OUT     = 3'd1;
  localparam logic [STATE_W-1:0] SUB     = 3'd2;
  localparam logic [STATE_W-1:0] UPD     = 3'd3;
`ifdef INV_KEY_EXP_FWD_DERIVE_EN
  localparam logic [STATE_W-1:0] FWD_SUB = 3'd4;
  localparam logic [STATE_W-1:0] FWD_UPD = 3'd5;
`endif

  localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd10;
  localparam logic [7:0]         RCON_LAST  = 8'h36;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

`ifdef INV_KEY_EXP_FWD_DERIVE_EN
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
`endif

  logic [STATE_W-1:0] state_q, state_d;
  logic [WORD_W-1:0]  w0_q, w1_q, w2_q, w3_q;
  logic [WORD_W-1:0]  w0_d, w1_d, w2_d, w3_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [7:0]         rcon_q, rcon_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WORD_W-1:0]  sub_q;
  logic [WORD_W-1:0]  sbox_in_c;
  logic               sub_en_c;
`ifdef INV_KEY_EXP_FWD_DERIVE_EN
  logic [WORD_W-1:0]  fw0_c, fw1_c, fw2_c, fw3_c;
`endif

  assign key_out   = {w3_q, w2_q, w1_q, w0_q};
  assign key_valid = valid_q;
  assign round_idx = round_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // S-box address select and load enable
  always_comb begin
`ifdef INV_KEY_EXP_FWD_DERIVE_EN
    sbox_in_c = (state_q == FWD_SUB) ? w3_q : (w3_q ^ w2_q);
    sub_en_c  = (state_q == SUB) || (state_q == FWD_SUB);
`else
    sbox_in_c = w3_q ^ w2_q;
    sub_en_c  = (state_q == SUB);
`endif
  end

  // RotWord folded into the byte placement; no reset since UPD always follows a load
  always_ff @(posedge clk) begin
    if (sub_en_c) begin
      sub_q <= {sbox(sbox_in_c[23:16]), sbox(sbox_in_c[15:8]),
                sbox(sbox_in_c[7:0]),   sbox(sbox_in_c[31:24])};
    end
  end

  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
`ifdef INV_KEY_EXP_FWD_DERIVE_EN
    fw0_c   = w0_q ^ sub_q ^ {rcon_q, 24'h0};
    fw1_c   = w1_q ^ fw0_c;
    fw2_c   = w2_q ^ fw1_c;
    fw3_c   = w3_q ^ fw2_c;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          // Words are presented little-endian per 32-bit lane on key_in
          w0_d = {key_in[7:0],   key_in[15:8],  key_in[23:16],  key_in[31:24]};
          w1_d = {key_in[39:32], key_in[47:40], key_in[55:48],  key_in[63:56]};
          w2_d = {key_in[71:64], key_in[79:72], key_in[87:80],  key_in[95:88]};
          w3_d = {key_in[103:96], key_in[111:104], key_in[119:112], key_in[127:120]};
`ifdef INV_KEY_EXP_FWD_DERIVE_EN
          round_d = 4'd0;
          rcon_d  = 8'h01;
          state_d = FWD_SUB;
`else
          round_d = LAST_ROUND;
          rcon_d  = RCON_LAST;
          state_d = OUT;
`endif
        end
      end
      OUT: begin
        if (key_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: state_d = UPD;
      UPD: begin
        w3_d    = w3_q ^ w2_q;
        w2_d    = w2_q ^ w1_q;
        w1_d    = w1_q ^ w0_q;
        w0_d    = w0_q ^ sub_q ^ {rcon_q, 24'h0};
        round_d = round_q - 4'd1;
        rcon_d  = (rcon_q == 8'h1b) ? 8'h80 : (rcon_q >> 1);
        state_d = OUT;
      end
`ifdef INV_KEY_EXP_FWD_DERIVE_EN
      FWD_SUB: state_d = FWD_UPD;
      FWD_UPD: begin
        w0_d    = fw0_c;
        w1_d    = fw1_c;
        w2_d    = fw2_c;
        w3_d    = fw3_c;
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND - 4'd1) begin
          rcon_d  = RCON_LAST;
          state_d = OUT;
        end else begin
          rcon_d  = xtime(rcon_q);
          state_d = FWD_SUB;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == OUT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      round_q <= '0;
      rcon_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: forward AES-128 expansion model, random keys and ready patterns.
module tb_inv_key_expansion;

  logic         clk = 1'b0;
  logic         rst, start, key_ready;
  logic [127:0] key_in, key_out;
  logic         key_valid, busy, done;
  logic [3:0]   round_idx;

  always #5 clk = ~clk;

  inv_key_expansion dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_ready(key_ready),
    .key_out(key_out), .key_valid(key_valid), .round_idx(round_idx),
    .busy(busy), .done(done)
  );

`ifdef INV_KEY_EXP_FWD_DERIVE_EN
  localparam int FIRST_CYC = 21;
`else
  localparam int FIRST_CYC = 1;
`endif

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [7:0]   sbox_m [0:255];
  logic [31:0]  w_m    [0:43];
  logic [127:0] cap    [0:10];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] xt8(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] byterev(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] wordrev(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = v[127-32*i -: 32];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // S-box by walking generator 3 and its inverse together
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_m[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_m[0] = 8'h63;
  endtask

  // Textbook forward expansion of a cipher key (FIPS byte order) into w[0..43]
  task automatic expand(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w_m[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w_m[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t  = t ^ {rc, 24'h0};
        rc = xt8(rc);
      end
      w_m[i] = w_m[i-4] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_key(input int r);
    return {w_m[4*r+3], w_m[4*r+2], w_m[4*r+1], w_m[4*r]};
  endfunction

  function automatic logic [127:0] port_key(input logic [127:0] ck);
`ifdef INV_KEY_EXP_FWD_DERIVE_EN
    return byterev(ck);
`else
    return byterev({w_m[40], w_m[41], w_m[42], w_m[43]});
`endif
  endfunction

  // mode 0: ready tied high, 1: 5-cycle stall at round 7, 2: random ready
  task automatic run_seq(input logic [127:0] ck, input int mode, input bit poke);
    int r, cnt, last_xfer, stall;
    bit new_round, rdy;
    expand(ck);
    @(negedge clk);
    start = 1'b1; key_in = port_key(ck); key_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; key_in = rand128();
    cnt = 1; r = 10; new_round = 1'b1; last_xfer = 0; stall = 0;
    while (r >= 0 && cnt < 400) begin
      rdy = 1'b0;
      if (key_valid) begin
        if (new_round) begin
          check("latency", 128'(cnt), 128'((r == 10) ? FIRST_CYC : last_xfer + 3));
          check("round_idx", 128'(round_idx), 128'(r));
          check("key", key_out, exp_key(r));
          cap[r] = key_out;
          new_round = 1'b0;
          if (mode == 1 && r == 7) stall = 5;
          if (poke && r == 5) begin
            start = 1'b1;
            key_in = rand128();
          end
        end else begin
          check("hold_key", key_out, exp_key(r));
          check("hold_idx", 128'(round_idx), 128'(r));
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (stall == 0);
          default: rdy = ($urandom_range(0, 2) != 0);
        endcase
        if (stall > 0) stall--;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      key_ready = rdy;
      if (key_valid && rdy) begin
        last_xfer = cnt;
        r--;
        new_round = 1'b1;
      end
      @(negedge clk);
      cnt++;
      start = 1'b0;
    end
    check("timeout_rounds_left", 128'(r + 1), 128'(0));
    key_ready = 1'b0;
    check("done_pulse", 128'(done), 128'(1));
    check("busy_end", 128'(busy), 128'(0));
    check("valid_end", 128'(key_valid), 128'(0));
    if (mode == 0) check("last_valid_cyc", 128'(last_xfer), 128'(FIRST_CYC + 30));
    @(negedge clk);
    check("done_clear", 128'(done), 128'(0));
  endtask

  task automatic reset_mid_upd();
    logic [127:0] ck;
    int cnt;
    bit seen;
    ck = rand128();
    expand(ck);
    @(negedge clk);
    start = 1'b1; key_in = port_key(ck); key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    // Third transfer lands at FIRST_CYC+6, so its UPD cycle is FIRST_CYC+8
    while (cnt < FIRST_CYC + 8) begin
      @(negedge clk);
      cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_key", key_out, 128'(0));
    check("rst_valid", 128'(key_valid), 128'(0));
    check("rst_idx", 128'(round_idx), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen = seen | key_valid | done | busy;
    end
    check("abort_quiet", 128'(seen), 128'(0));
    key_ready = 1'b0;
    run_seq(ck, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("reset_key", key_out, 128'(0));
    check("reset_valid", 128'(key_valid), 128'(0));
    check("reset_idx", 128'(round_idx), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    rst = 1'b0;

    run_seq(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0);
    check("fips_r10", cap[10], wordrev(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    check("fips_r9",  cap[9],  wordrev(128'hac7766f319fadc2128d12941575c006e));
    check("fips_r0",  cap[0],  wordrev(128'h2b7e151628aed2a6abf7158809cf4f3c));

    run_seq(rand128(), 1, 1'b0);
    run_seq(rand128(), 0, 1'b1);
    repeat (4) run_seq(rand128(), 2, 1'b0);

    reset_mid_upd();

    @(negedge clk);
    rst = 1'b1; start = 1'b1; key_in = rand128();
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 128'(busy), 128'(0));
    check("rst_start_valid", 128'(key_valid), 128'(0));
    repeat (3) @(negedge clk);
    check("rst_start_idle", 128'(busy), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inv_key_expansion.md
INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: start  input  1  one-cycle request to begin a reverse schedule.
REQ-004 SHALL have: key_in  input  128  start key, sampled only when start is accepted.
REQ-005 SHALL have: key_ready  input  1  consumer accepts key_out this cycle.
REQ-006 SHALL have: key_out  output  128  current round key, {W3,W2,W1,W0}.
REQ-007 SHALL have: key_valid  output  1  key_out/round_idx valid.
REQ-008 SHALL have: round_idx  output  4  round number of key_out, 10 down to 0.
REQ-009 SHALL have: busy  output  1  high from accepted start until done.
REQ-010 SHALL have: done  output  1  one-cycle pulse after the round-0 transfer.

Function
REQ-011 SHALL load words byte-swapped: W0={key_in[7:0],[15:8],[23:16],[31:24]}; W1..W3 likewise from bits 63:32, 95:64, 127:96.
REQ-012 SHALL use FSM states IDLE, OUT, SUB, UPD (plus FWD_SUB, FWD_UPD per REQ-025).
REQ-013 SHALL accept start only in IDLE. Start while busy is ignored with no state change.
REQ-014 IDLE+start: load words, round_idx=10, rcon=0x36, go to OUT. key_valid high in the next cycle.
REQ-015 In OUT, key_valid=1. key_out and round_idx SHALL be held stable while key_ready=0.
REQ-016 On OUT transfer (key_valid&key_ready): if round_idx=0, go to IDLE with done=1 for that next cycle; else go to SUB.
REQ-017 In SUB, four registered sbox instances SHALL be addressed with P3=W3^W2, applying RotWord:
- result byte[31:24]=S(P3[23:16])
- [23:16]=S(P3[15:8])
- [15:8]=S(P3[7:0])
- [7:0]=S(P3[31:24])
REQ-018 In UPD, the block SHALL write:
- W3<=W3^W2, W2<=W2^W1, W1<=W1^W0
- W0<=W0^SubRot^{rcon,24'h0}
then decrement round_idx, set rcon<=(rcon==0x1b)?0x80:rcon>>1, and go to OUT.
REQ-019 Transfer in cycle t SHALL give the next key_valid in cycle t+3. With key_ready tied high, the last valid SHALL be 31 cycles after start (no FWD).
REQ-020 key_valid SHALL be 0 outside OUT. busy SHALL be 0 only in IDLE.

Reset
REQ-021 rst SHALL force IDLE and set key_out=0, key_valid=0, round_idx=0, busy=0, done=0, rcon=0.
REQ-022 rst SHALL take priority over start and key_ready in the same cycle.
REQ-023 rst mid-schedule SHALL abort with no further key_valid or done.
REQ-024 Sbox output registers need no reset. Their contents SHALL never reach outputs before an UPD.

Configuration
REQ-025 Macro INV_KEY_EXP_FWD_DERIVE_EN, when defined:
- key_in is the cipher (round-0) key.
- start goes to FWD_SUB with rcon=0x01.
- Sbox address is W3 with the same RotWord mapping.
- FWD_UPD SHALL write W0'=W0^SubRot^rcon, W1'=W1^W0', W2'=W2^W1', W3'=W3^W2', then rcon<=xtime(rcon).
- After 10 FWD_SUB/FWD_UPD pairs, go to OUT with round_idx=10 and rcon=0x36. First key_valid SHALL be 21 cycles after start.
REQ-026 Macro undefined: key_in is the round-10 key, the FWD states do not exist, and timing is per REQ-019.

Verification
REQ-027 No FWD; key_in=round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6 (FIPS-197 A.1, word-swapped per REQ-011), key_ready=1 -> 11 keys, round_idx 10..0. Round 9 = ac7766f319fadc2128d12941575c006e; round 0 = 2b7e151628aed2a6abf7158809cf4f3c. done is a pulse 1 cycle after round 0.
REQ-028 key_ready=0 for 5 cycles at round 7 -> key_out/round_idx held constant, no skipped or duplicated round.
REQ-029 start asserted during round 5 -> ignored, sequence unchanged.
REQ-030 rst asserted in a UPD cycle, then start with the same key -> outputs 0 for 1 cycle after rst; the full sequence then restarts at round 10.
REQ-031 rst and start in the same cycle -> block stays IDLE, busy=0.
REQ-032 FWD defined; key_in=2b7e...4f3c -> first valid at cycle 21, round-10 key d014f9a8...b6630ca6, then the same sequence as REQ-027.
